// File: rtl/store_commit_drain_pkg.sv
// Shared types for the committed-store drain path.
//   StoreDrainState     : drain FSM states
//   StoreQueueIndexPath : store queue index (default SQ depth)
//   StoreQueueCountPath : 0..SQ_ENTRY_NUM occupancy count (default SQ depth)
//   StoreDrainRequest   : one D-cache write request (default widths)
// The SD_* constants are the default configuration; the top module derives
// its own widths from its parameters so non-default builds stay consistent.
package StoreDrainTypes;

  localparam int SD_COMMIT_WIDTH = 2;
  localparam int SD_SQ_ENTRY_NUM = 16;
  localparam int SD_ADDR_WIDTH   = 32;
  localparam int SD_DATA_WIDTH   = 32;

  typedef enum logic [1:0] {
    STORE_DRAIN_IDLE,
    STORE_DRAIN_READ,
    STORE_DRAIN_SEND
  } StoreDrainState;

  typedef logic [$clog2(SD_SQ_ENTRY_NUM)-1:0]   StoreQueueIndexPath;
  typedef logic [$clog2(SD_SQ_ENTRY_NUM+1)-1:0] StoreQueueCountPath;

  typedef struct packed {
    logic [SD_ADDR_WIDTH-1:0]   addr;
    logic [SD_DATA_WIDTH-1:0]   data;
    logic [SD_DATA_WIDTH/8-1:0] be;
  } StoreDrainRequest;

endpackage

// File: rtl/store_commit_drain_if.sv
// D-cache write port handshake.
//   dc_wr_valid / dc_wr_ready : valid/ready handshake
//   dc_wr_addr / data / be    : request payload, stable while valid && !ready
// master = drain side (drives request), slave = D-cache side.
interface store_commit_drain_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    dc_wr_valid;
  logic                    dc_wr_ready;
  logic [ADDR_WIDTH-1:0]   dc_wr_addr;
  logic [DATA_WIDTH-1:0]   dc_wr_data;
  logic [DATA_WIDTH/8-1:0] dc_wr_be;

  modport master (output dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
                  input  dc_wr_ready);
  modport slave  (input  dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
                  output dc_wr_ready);
endinterface

// File: rtl/store_commit_drain_pending_counter.sv
// Count of committed-but-unwritten stores.
//   commit_store/commit_store_num : stores committed this cycle
//   wr_accept                     : one store written this cycle
//   pending                       : registered count
//   pending_next                  : count after this cycle (saturated)
//   overflow_err                  : sticky, set when the count would exceed
//                                   SQ_ENTRY_NUM; cleared only by reset
module store_drain_pending_counter #(
  parameter int COMMIT_WIDTH = 2,
  parameter int SQ_ENTRY_NUM = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                commit_store,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]   commit_store_num,
  input  logic                                wr_accept,
  output logic [$clog2(SQ_ENTRY_NUM+1)-1:0]   pending,
  output logic [$clog2(SQ_ENTRY_NUM+1)-1:0]   pending_next,
  output logic                                overflow_err
);
  localparam int CNT_W = $clog2(SQ_ENTRY_NUM+1);
  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [SUM_W-1:0] sum;

  // One extra bit of headroom so a commit on a full count is visible.
  // A decrement only happens while a request is outstanding, so pending >= 1
  // whenever wr_accept is set and the sum never underflows.
  always_comb begin
    sum = {1'b0, pending_q}
        + (commit_store ? SUM_W'(commit_store_num) : '0)
        - (wr_accept ? SUM_W'(1) : '0);
    overflow_d = overflow_q;
    if (sum > SUM_W'(SQ_ENTRY_NUM)) begin
      pending_d  = CNT_W'(SQ_ENTRY_NUM);
      overflow_d = 1'b1;
    end else begin
      pending_d  = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending      = pending_q;
  assign pending_next = pending_d;
  assign overflow_err = overflow_q;

endmodule

// File: rtl/store_commit_drain.sv
// Drains committed stores from the store queue head to the D-cache write
// port, one request at a time, and answers fences once everything committed
// has been written. Pipeline recovery never touches this block.
//   clk, rst (async active-low)
//   commit_store/commit_store_num : committed-store count from commit stage
//   sq_rd_ptr, sq_rd_addr/data/be : store queue head read (data valid by the
//                                   cycle after the pointer)
//   dc_wr                         : D-cache write handshake (master side)
//   sq_release                    : head entry freed (pulse on handshake)
//   fence_req/fence_done          : fence waits for full drain
//   pending_count, overflow_err   : drain backlog and sticky overflow flag
// Optional macro RSD_STORE_DRAIN_PERF_EN adds perf_write_count and
// perf_stall_cycles (32-bit, wrapping).
module store_commit_drain
  import StoreDrainTypes::*;
#(
  parameter int COMMIT_WIDTH = SD_COMMIT_WIDTH,
  parameter int SQ_ENTRY_NUM = SD_SQ_ENTRY_NUM,
  parameter int ADDR_WIDTH   = SD_ADDR_WIDTH,
  parameter int DATA_WIDTH   = SD_DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                commit_store,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]   commit_store_num,
  output logic [$clog2(SQ_ENTRY_NUM)-1:0]     sq_rd_ptr,
  input  logic [ADDR_WIDTH-1:0]               sq_rd_addr,
  input  logic [DATA_WIDTH-1:0]               sq_rd_data,
  input  logic [DATA_WIDTH/8-1:0]             sq_rd_be,
  store_commit_drain_if.master                dc_wr,
  output logic                                sq_release,
  input  logic                                fence_req,
  output logic                                fence_done,
  output logic [$clog2(SQ_ENTRY_NUM+1)-1:0]   pending_count,
  output logic                                overflow_err
`ifdef RSD_STORE_DRAIN_PERF_EN
  ,
  output logic [31:0]                         perf_write_count,
  output logic [31:0]                         perf_stall_cycles
`endif
);
  localparam int IDX_W = $clog2(SQ_ENTRY_NUM);
  localparam int CNT_W = $clog2(SQ_ENTRY_NUM+1);
  localparam int BE_W  = DATA_WIDTH/8;

  StoreDrainState          state_q, state_d;
  logic [IDX_W-1:0]        head_q, head_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic                    fence_done_q, fence_done_d;
  logic [CNT_W-1:0]        pending, pending_next;
  logic                    wr_accept;

  assign wr_accept = valid_q && dc_wr.dc_wr_ready;

  store_drain_pending_counter #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .SQ_ENTRY_NUM (SQ_ENTRY_NUM)
  ) u_pending (
    .clk              (clk),
    .rst              (rst),
    .commit_store     (commit_store),
    .commit_store_num (commit_store_num),
    .wr_accept        (wr_accept),
    .pending          (pending),
    .pending_next     (pending_next),
    .overflow_err     (overflow_err)
  );

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    unique case (state_q)
      STORE_DRAIN_IDLE: if (pending != '0) state_d = STORE_DRAIN_READ;
      // Head entry is presented on sq_rd_* during READ; latch it on the way
      // into SEND so the payload is frozen for the whole handshake.
      STORE_DRAIN_READ: begin
        state_d = STORE_DRAIN_SEND;
        valid_d = 1'b1;
        addr_d  = sq_rd_addr;
        data_d  = sq_rd_data;
        be_d    = sq_rd_be;
      end
      STORE_DRAIN_SEND: if (dc_wr.dc_wr_ready) begin
        valid_d = 1'b0;
        head_d  = head_q + IDX_W'(1);  // power-of-two depth wraps naturally
        state_d = (pending_next != '0) ? STORE_DRAIN_READ : STORE_DRAIN_IDLE;
      end
      default: state_d = STORE_DRAIN_IDLE;
    endcase
    // A store committing this very cycle shows up in pending_next and holds
    // the fence off.
    fence_done_d = fence_req && (state_q == STORE_DRAIN_IDLE)
                && (pending == '0) && (pending_next == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STORE_DRAIN_IDLE;
      head_q       <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      fence_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      be_q         <= be_d;
      fence_done_q <= fence_done_d;
    end
  end

  assign sq_rd_ptr         = head_q;
  assign dc_wr.dc_wr_valid = valid_q;
  assign dc_wr.dc_wr_addr  = addr_q;
  assign dc_wr.dc_wr_data  = data_q;
  assign dc_wr.dc_wr_be    = be_q;
  assign sq_release        = wr_accept;
  assign fence_done        = fence_done_q;
  assign pending_count     = pending;

`ifdef RSD_STORE_DRAIN_PERF_EN
  logic [31:0] perf_write_q, perf_write_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_write_d = perf_write_q + 32'(wr_accept);
    perf_stall_d = perf_stall_q + 32'(valid_q && !dc_wr.dc_wr_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_write_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_write_q <= perf_write_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_write_count  = perf_write_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_store_commit_drain.sv
module tb_store_commit_drain;
  import StoreDrainTypes::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_store;
  logic [1:0]  commit_store_num;
  logic [3:0]  sq_rd_ptr;
  logic [31:0] sq_rd_addr, sq_rd_data;
  logic [3:0]  sq_rd_be;
  logic        sq_release, fence_req, fence_done, overflow_err;
  logic [4:0]  pending_count;
`ifdef RSD_STORE_DRAIN_PERF_EN
  logic [31:0] perf_write_count, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  store_commit_drain_if dif();

  store_commit_drain dut (
    .clk              (clk),
    .rst              (rst),
    .commit_store     (commit_store),
    .commit_store_num (commit_store_num),
    .sq_rd_ptr        (sq_rd_ptr),
    .sq_rd_addr       (sq_rd_addr),
    .sq_rd_data       (sq_rd_data),
    .sq_rd_be         (sq_rd_be),
    .dc_wr            (dif),
    .sq_release       (sq_release),
    .fence_req        (fence_req),
    .fence_done       (fence_done),
    .pending_count    (pending_count),
    .overflow_err     (overflow_err)
`ifdef RSD_STORE_DRAIN_PERF_EN
    ,
    .perf_write_count (perf_write_count),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // Store queue contents; the head entry is always presented on sq_rd_*.
  StoreDrainRequest mem [16];
  assign sq_rd_addr = mem[sq_rd_ptr].addr;
  assign sq_rd_data = mem[sq_rd_ptr].data;
  assign sq_rd_be   = mem[sq_rd_ptr].be;

  int checks = 0;
  int errors = 0;

  // Reference model: backlog count, next store to be written, sticky flag.
  int m_pend, m_head;
  bit m_ovf, hold_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the live request against the model before the edge,
  // advance the model across the edge, then check registered state.
  task automatic cyc();
    bit acc, fexp;
    int inc;
    @(negedge clk);
    acc = dif.dc_wr_valid && dif.dc_wr_ready;
    check("release", sq_release, acc);
    if (hold_prev) check("valid_held", dif.dc_wr_valid, 1'b1);
    if (m_pend == 0) check("spurious_valid", dif.dc_wr_valid, 1'b0);
    if (dif.dc_wr_valid) begin
      check("wr_addr", dif.dc_wr_addr, mem[m_head].addr);
      check("wr_data", dif.dc_wr_data, mem[m_head].data);
      check("wr_be",   dif.dc_wr_be,   mem[m_head].be);
    end
    hold_prev = dif.dc_wr_valid && !dif.dc_wr_ready;
    inc  = commit_store ? int'(commit_store_num) : 0;
    fexp = fence_req && (m_pend == 0) && (inc == 0);
    if (acc) m_head = (m_head + 1) % 16;
    @(posedge clk); #1;
    m_pend = m_pend + inc - int'(acc);
    if (m_pend > 16) begin m_pend = 16; m_ovf = 1'b1; end
    check("pending", pending_count, m_pend);
    check("overflow", overflow_err, m_ovf);
    check("rd_ptr", sq_rd_ptr, m_head);
    check("fence_done", fence_done, fexp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},   dif.dc_wr_valid, 1'b0);
    check({tag, "_addr"},    dif.dc_wr_addr, 32'h0);
    check({tag, "_data"},    dif.dc_wr_data, 32'h0);
    check({tag, "_be"},      dif.dc_wr_be, 4'h0);
    check({tag, "_release"}, sq_release, 1'b0);
    check({tag, "_fence"},   fence_done, 1'b0);
    check({tag, "_pending"}, pending_count, 5'd0);
    check({tag, "_ovf"},     overflow_err, 1'b0);
    check({tag, "_ptr"},     sq_rd_ptr, 4'd0);
  endtask

  // Asynchronous reset mid-cycle, released after the next edge.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk); #1;
    commit_store = 1'b0;
    rst = 1'b1;
    m_pend = 0; m_head = 0; m_ovf = 1'b0; hold_prev = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ev [6];
    bit extra;
    int q [$];

    for (int i = 0; i < 16; i++) begin
      mem[i].addr = $urandom;
      mem[i].data = $urandom;
      mem[i].be   = 4'($urandom);
    end
    rst = 1'b0; commit_store = 1'b0; commit_store_num = 2'd0;
    fence_req = 1'b0; dif.dc_wr_ready = 1'b0;
    m_pend = 0; m_head = 0; m_ovf = 1'b0; hold_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b1;

    // Reset while a request is outstanding.
    commit_store = 1'b1; commit_store_num = 2'd1;
    cyc();
    commit_store = 1'b0;
    cyc(); cyc();
    check("t1_in_send", dif.dc_wr_valid, 1'b1);
    do_reset();
    cyc(); check("t1_quiet0", dif.dc_wr_valid, 1'b0);
    cyc(); check("t1_quiet1", dif.dc_wr_valid, 1'b0);

    // Two stores, ready tied high: requests on cycles 2 and 4.
    dif.dc_wr_ready = 1'b1;
    commit_store = 1'b1; commit_store_num = 2'd2;
    cyc();
    commit_store = 1'b0;
    check("t2_c0_valid", dif.dc_wr_valid, 1'b0);
    ev = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i < 6; i++) begin
      cyc();
      check("t2_valid", dif.dc_wr_valid, ev[i]);
      check("t2_release", sq_release, ev[i]);
      if (i == 2) check("t2_ptr0", sq_rd_ptr, 4'd0);
      if (i == 4) check("t2_ptr1", sq_rd_ptr, 4'd1);
    end

    // Back-pressure for five SEND cycles.
    dif.dc_wr_ready = 1'b0;
    commit_store = 1'b1; commit_store_num = 2'd1;
    cyc();
    commit_store = 1'b0;
    cyc(); cyc();
    check("t3_send", dif.dc_wr_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t3_stall_valid", dif.dc_wr_valid, 1'b1);
      check("t3_stall_release", sq_release, 1'b0);
    end
    dif.dc_wr_ready = 1'b1;
    #1 check("t3_accept_release", sq_release, 1'b1);
    cyc();
    check("t3_after", dif.dc_wr_valid, 1'b0);

    // Head wrap: advance head to 15, then two more stores.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      commit_store = 1'b1; commit_store_num = (i < 7) ? 2'd2 : 2'd1;
      cyc();
    end
    commit_store = 1'b0;
    for (int i = 0; i < 200 && m_pend != 0; i++) cyc();
    check("t4_head15", sq_rd_ptr, 4'd15);
    commit_store = 1'b1; commit_store_num = 2'd2;
    cyc();
    commit_store = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (dif.dc_wr_valid) q.push_back(int'(sq_rd_ptr));
    end
    check("t4_nreq", q.size(), 2);
    if (q.size() >= 2) begin
      check("t4_first", q[0], 15);
      check("t4_wrap", q[1], 0);
    end

    // Saturation and sticky overflow.
    do_reset();
    dif.dc_wr_ready = 1'b0;
    commit_store = 1'b1; commit_store_num = 2'd2;
    repeat (8) cyc();
    check("t5_full", pending_count, 5'd16);
    check("t5_no_ovf", overflow_err, 1'b0);
    commit_store_num = 2'd1;
    cyc();
    check("t5_clamp", pending_count, 5'd16);
    check("t5_ovf", overflow_err, 1'b1);
    commit_store = 1'b0; dif.dc_wr_ready = 1'b1;
    repeat (10) cyc();
    check("t5_sticky", overflow_err, 1'b1);
    do_reset();

    // Fence with a store committed in the cycle of the last accept.
    fence_req = 1'b1; dif.dc_wr_ready = 1'b1;
    commit_store = 1'b1; commit_store_num = 2'd2;
    cyc();
    commit_store_num = 2'd1;
    cyc();
    extra = 1'b0;
    for (int i = 0; i < 60 && !fence_done; i++) begin
      commit_store = 1'b0;
      if (!extra && dif.dc_wr_valid && pending_count == 5'd1) begin
        commit_store = 1'b1; commit_store_num = 2'd1; extra = 1'b1;
      end
      cyc();
    end
    commit_store = 1'b0;
    check("t6_extra_seen", extra, 1'b1);
    check("t6_fence_done", fence_done, 1'b1);
    check("t6_drained", pending_count, 5'd0);
    fence_req = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      commit_store     = 1'($urandom);
      commit_store_num = 2'($urandom_range(0, 2));
      if (m_pend > 13) commit_store_num = 2'd0;
      dif.dc_wr_ready  = ($urandom_range(0, 3) != 0);
      fence_req        = ($urandom_range(0, 3) == 0);
      cyc();
    end
    commit_store = 1'b0; dif.dc_wr_ready = 1'b1; fence_req = 1'b1;
    for (int i = 0; i < 100 && m_pend != 0; i++) cyc();
    cyc(); cyc();
    check("final_pending", pending_count, 5'd0);
    check("final_fence", fence_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_commit_drain.md
Name: store_commit_drain

Overview:
- Sits directly downstream of the commit stage, alongside the load/store unit.
- Receives committed-store counts each cycle.
- Reads committed entries from the store queue head and issues them, one at a time, to the D-cache write port over a valid/ready handshake, then releases each entry.
- Committed stores are architectural, so pipeline recovery never flushes this block; it also answers fence requests once all committed stores have drained.

Parameters:
- COMMIT_WIDTH, 2, max ops committed per cycle.
- SQ_ENTRY_NUM, 16, store queue depth; must be a power of two.
- ADDR_WIDTH, 32, store address width.
- DATA_WIDTH, 32, store data width; byte-enable width = DATA_WIDTH/8.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- commit_store  input  1  commit stage committed ≥1 op this cycle
- commit_store_num  input  $clog2(COMMIT_WIDTH+1)  stores committed this cycle
- sq_rd_ptr  output  $clog2(SQ_ENTRY_NUM)  store queue read index
- sq_rd_addr  input  ADDR_WIDTH  entry address, valid one cycle after sq_rd_ptr
- sq_rd_data  input  DATA_WIDTH  entry data, same timing
- sq_rd_be  input  DATA_WIDTH/8  entry byte enables, same timing
- dc_wr_valid  output  1  write request valid
- dc_wr_ready  input  1  D-cache accepts request
- dc_wr_addr  output  ADDR_WIDTH  request address
- dc_wr_data  output  DATA_WIDTH  request data
- dc_wr_be  output  DATA_WIDTH/8  request byte enables
- sq_release  output  1  one-cycle pulse; head entry freed
- fence_req  input  1  level; fence waiting on drain
- fence_done  output  1  all committed stores written
- pending_count  output  $clog2(SQ_ENTRY_NUM+1)  committed but unwritten stores
- overflow_err  output  1  sticky; pending would exceed SQ_ENTRY_NUM

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; head = 0; pending = 0.
  - All outputs 0; dc_wr_* payload registers 0.
- Pending arithmetic, evaluated every cycle:
  - pending_next = pending + (commit_store ? commit_store_num : 0) − (dc_wr_valid && dc_wr_ready ? 1 : 0).
  - Compute at width $clog2(SQ_ENTRY_NUM+1)+1.
  - If pending_next > SQ_ENTRY_NUM: clamp to SQ_ENTRY_NUM and set overflow_err; overflow_err clears only on reset.
  - commit_store = 1 with commit_store_num = 0 is a no-op.
  - A same-cycle commit and accepted write both apply.
- sq_rd_ptr always equals head.
- Head increments by 1 on each accepted write, wrapping modulo SQ_ENTRY_NUM (SQ_ENTRY_NUM−1 → 0).
- FSM:
  - IDLE: if pending > 0 (registered value) → READ; otherwise stay.
  - READ: store queue performs its synchronous read of head; → SEND. At the SEND entry edge, capture sq_rd_addr/data/be into the dc_wr_* registers.
  - SEND: dc_wr_valid = 1. Payload and valid are held stable until dc_wr_ready.
    - On handshake: sq_release pulses in the same cycle and head++.
    - Next state is READ if pending_next > 0, else IDLE.
- Throughput: at most one write per two cycles.
- Latency: first dc_wr_valid occurs 2 cycles after the commit edge that makes pending nonzero.
- fence_done = fence_req && state == IDLE && pending == 0, registered (one-cycle lag). A store committed in the same cycle as the check blocks fence_done.
- Recovery/flush inputs: none. Committed stores always drain.
- Reset mid-SEND: the request is dropped. Memory consistency after reset is not guaranteed.

Optional Feature:
- Macro: RSD_STORE_DRAIN_PERF_EN.
- When defined, adds outputs:
  - perf_write_count (32b): accepted writes.
  - perf_stall_cycles (32b): cycles in SEND with dc_wr_ready = 0.
  - Both wrap at 2^32 and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package StoreDrainTypes holds:
  - enum StoreDrainState {STORE_DRAIN_IDLE, STORE_DRAIN_READ, STORE_DRAIN_SEND};
  - typedefs StoreQueueIndexPath and StoreQueueCountPath derived from SQ_ENTRY_NUM;
  - struct StoreDrainRequest {addr, data, be}.
- One sub-module, store_drain_pending_counter: pending arithmetic, saturation and overflow_err.

Test Plan:
- Reset with rst = 0 mid-SEND, then release → all outputs 0, state IDLE, head 0, no dc_wr_valid for 2 cycles.
- commit_store = 1, num = 2 at cycle 0, ready tied 1:
  - dc_wr_valid at cycles 2 and 4 with sq_rd_ptr 0 then 1.
  - sq_release pulses at cycles 2 and 4.
  - pending 2→1→0.
- dc_wr_ready held 0 for 5 SEND cycles → addr/data/be stable throughout; single release on the accepting cycle.
- Head at 15 (SQ_ENTRY_NUM = 16), commit 2 → sq_rd_ptr goes 15 then wraps to 0.
- pending = 16, commit 1 with no accept → pending stays 16 and overflow_err = 1 until reset.
- fence_req = 1 with 3 pending, plus a commit in the cycle the last write is accepted → fence_done stays 0 until that extra store drains, then asserts one cycle after IDLE with pending = 0.
